// File: rtl/udp_line_pkg.sv
// Shared constants and enums for the camera-line UDP receiver.
// Tags, header field widths, error codes and FSM states.
package udp_line_pkg;
  localparam int TAG_W = 6;
  localparam int ROW_W = 10;

  localparam logic [TAG_W-1:0] ID_CAM1 = 6'b010101;
  localparam logic [TAG_W-1:0] ID_CAM2 = 6'b101010;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_LEN     = 3'd1,
    ERR_ID      = 3'd2,
    ERR_RANGE   = 3'd3,
    ERR_TRUNC   = 3'd4,
    ERR_OVERRUN = 3'd5,
    ERR_SEQ     = 3'd6
  } err_code_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_TAIL,
    ST_DROP
  } state_e;
endpackage

// File: rtl/row_seq_tracker.sv
// Per-camera expected-row registers: compared against each accepted header,
// advanced (with frame wrap) when a line completes.
module row_seq_tracker
  import udp_line_pkg::*;
#(
  parameter int V_ACT = 720
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             chk_cam,
  input  logic [ROW_W-1:0] chk_row,
  input  logic             upd,
  input  logic             upd_cam,
  input  logic [ROW_W-1:0] upd_row,
  output logic             mismatch
);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_ACT - 1);

  logic [ROW_W-1:0] exp_cam1;
  logic [ROW_W-1:0] exp_cam2;
  logic [ROW_W-1:0] row_next;

  assign mismatch = chk_row != (chk_cam ? exp_cam1 : exp_cam2);
  assign row_next = (upd_row == ROW_LAST) ? '0 : upd_row + 10'd1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      exp_cam1 <= '0;
      exp_cam2 <= '0;
    end else if (upd) begin
      if (upd_cam) exp_cam1 <= row_next;
      else         exp_cam2 <= row_next;
    end
  end
endmodule

// File: rtl/udp_line_receiver.sv
// Parses and validates camera-line UDP payloads, emitting pixel bytes with
// column/row/camera coordinates and reporting per-packet errors.
module udp_line_receiver
  import udp_line_pkg::*;
#(
  parameter int H_ACT = 1280,
  parameter int V_ACT = 720
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic [15:0] rx_data_len,
  output logic        o_valid,
  output logic [7:0]  o_data,
  output logic [10:0] o_col,
  output logic [9:0]  o_row,
  output logic        o_cam_id,
  output logic        line_done,
  output logic        err,
  output logic [2:0]  err_code,
  output logic [15:0] err_cnt
);
  // state   | meaning
  // IDLE    | waiting for first payload byte
  // HDR     | high index byte held, second byte completes and validates header
  // DATA    | emitting pixel bytes
  // TAIL    | full line received, packet must end now
  // DROP    | discarding the rest of a rejected packet
  localparam logic [15:0]      LEN_OK   = 16'(H_ACT + 2);
  localparam logic [10:0]      COL_LAST = 11'(H_ACT - 1);
  localparam logic [ROW_W:0]   ROW_END  = (ROW_W + 1)'(V_ACT);

  state_e           state, state_d;
  logic [7:0]       hdr_hi;
  logic [15:0]      len_q;
  logic [10:0]      col;
  logic [TAG_W-1:0] hdr_tag;
  logic [ROW_W-1:0] hdr_row;
  logic             hdr_cam1;
  logic             seq_mismatch;
  logic             capture, accept, emit, done_set, err_set;
  err_code_e        err_d;

  assign hdr_tag  = hdr_hi[7:2];
  assign hdr_row  = {hdr_hi[1:0], rx_data};
  assign hdr_cam1 = hdr_tag == ID_CAM1;

  always_comb begin
    state_d  = state;
    capture  = 1'b0;
    accept   = 1'b0;
    emit     = 1'b0;
    done_set = 1'b0;
    err_set  = 1'b0;
    err_d    = ERR_NONE;
    case (state)
      ST_IDLE: if (rx_valid) begin
        capture = 1'b1;
        state_d = ST_HDR;
      end
      ST_HDR: begin
        err_set = 1'b1;
        state_d = ST_DROP;
        if (!rx_valid) begin
          err_d   = ERR_TRUNC;
          state_d = ST_IDLE;
        end else if (len_q != LEN_OK) err_d = ERR_LEN;
        else if (!hdr_cam1 && hdr_tag != ID_CAM2) err_d = ERR_ID;
        else if ({1'b0, hdr_row} >= ROW_END) err_d = ERR_RANGE;
        else begin
          // sequence gaps are only a warning: the line is still delivered
          accept  = 1'b1;
          state_d = ST_DATA;
          err_set = seq_mismatch;
          err_d   = ERR_SEQ;
        end
      end
      ST_DATA: begin
        if (!rx_valid) begin
          err_set = 1'b1;
          err_d   = ERR_TRUNC;
          state_d = ST_IDLE;
        end else begin
          emit = 1'b1;
          if (col == COL_LAST) state_d = ST_TAIL;
        end
      end
      ST_TAIL: begin
        if (rx_valid) begin
          err_set = 1'b1;
          err_d   = ERR_OVERRUN;
          state_d = ST_DROP;
        end else begin
          done_set = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_DROP: if (!rx_valid) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      hdr_hi    <= '0;
      len_q     <= '0;
      col       <= '0;
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_col     <= '0;
      o_row     <= '0;
      o_cam_id  <= 1'b0;
      line_done <= 1'b0;
      err       <= 1'b0;
      err_code  <= '0;
      err_cnt   <= '0;
    end else begin
      state     <= state_d;
      o_valid   <= emit;
      line_done <= done_set;
      err       <= err_set;
      if (capture) begin
        hdr_hi <= rx_data;
        len_q  <= rx_data_len;
      end
      if (accept) begin
        col      <= '0;
        o_row    <= hdr_row;
        o_cam_id <= hdr_cam1;
      end else if (emit) begin
        col <= col + 11'd1;
      end
      if (emit) begin
        o_data <= rx_data;
        o_col  <= col;
      end
      if (err_set) begin
        err_code <= err_d;
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      end
    end
  end

  row_seq_tracker #(.V_ACT(V_ACT)) u_seq (
    .clk      (clk),
    .rstn     (rstn),
    .chk_cam  (hdr_cam1),
    .chk_row  (hdr_row),
    .upd      (done_set),
    .upd_cam  (o_cam_id),
    .upd_row  (o_row),
    .mismatch (seq_mismatch)
  );
endmodule

// File: tb/tb_udp_line_receiver.sv
// Directed bench for udp_line_receiver; a packet model fills pixel and
// error scoreboards that a monitor drains as the DUT produces output.
module tb_udp_line_receiver;
  localparam int          NPIX     = 1280;
  localparam logic [15:0] GOOD_LEN = 16'd1282;
  localparam logic [5:0]  CAM1     = 6'b010101;
  localparam logic [5:0]  CAM2     = 6'b101010;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [15:0] rx_data_len;
  logic        o_valid;
  logic [7:0]  o_data;
  logic [10:0] o_col;
  logic [9:0]  o_row;
  logic        o_cam_id;
  logic        line_done;
  logic        err;
  logic [2:0]  err_code;
  logic [15:0] err_cnt;

  typedef struct {
    logic [7:0]  d;
    logic [10:0] c;
    logic [9:0]  r;
    logic        cam;
  } pix_t;

  pix_t       pix_q[$];
  logic [2:0] err_q[$];
  logic [9:0] m_exp[2];
  int total = 0, bad = 0;
  int done_cnt = 0, pix_cnt = 0, exp_done = 0, exp_err_cnt = 0;
  int pix_mark;

  udp_line_receiver dut (
    .clk(clk), .rstn(rstn), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_data_len(rx_data_len), .o_valid(o_valid), .o_data(o_data),
    .o_col(o_col), .o_row(o_row), .o_cam_id(o_cam_id), .line_done(line_done),
    .err(err), .err_code(err_code), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic push_err(input logic [2:0] code);
    err_q.push_back(code);
    exp_err_cnt++;
  endtask

  // Expected behaviour of one packet: header bytes, length field, pixel-byte count.
  task automatic model_pkt(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [15:0] len, input int npix, input int off);
    logic [5:0] tag;
    logic [9:0] row;
    int         cam;
    pix_t       p;
    tag = b0[7:2];
    row = {b0[1:0], b1};
    cam = (tag == CAM1) ? 1 : 0;
    if (len != GOOD_LEN) push_err(3'd1);
    else if (tag != CAM1 && tag != CAM2) push_err(3'd2);
    else if (row >= 10'd720) push_err(3'd3);
    else begin
      if (row != m_exp[cam]) push_err(3'd6);
      for (int j = 0; j < NPIX && j < npix; j++) begin
        p.d = 8'(j + off); p.c = 11'(j); p.r = row; p.cam = cam[0];
        pix_q.push_back(p);
      end
      if (npix < NPIX) push_err(3'd4);
      else if (npix > NPIX) push_err(3'd5);
      else begin
        exp_done++;
        m_exp[cam] = (row == 10'd719) ? 10'd0 : row + 10'd1;
      end
    end
  endtask

  task automatic send_pkt(input logic [5:0] tag, input logic [9:0] row,
                          input logic [15:0] len, input int npix);
    logic [7:0] b0, b1;
    b0 = {tag, row[9:8]};
    b1 = row[7:0];
    model_pkt(b0, b1, len, npix, 0);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = b0; rx_data_len = len;
    @(negedge clk);
    rx_data = b1;
    for (int j = 0; j < npix; j++) begin
      @(negedge clk);
      rx_data = 8'(j);
    end
    @(negedge clk);
    rx_valid = 1'b0; rx_data = '0;
    repeat (4) @(negedge clk);
  endtask

  always @(posedge clk) begin
    pix_t p;
    #1;
    if (rstn) begin
      if (o_valid) begin
        pix_cnt++;
        total++;
        assert (pix_q.size() != 0) else begin
          bad++;
          $error("FAIL pix_unexpected observed_col=%0d expected=none", o_col);
        end
        if (pix_q.size() != 0) begin
          p = pix_q.pop_front();
          total++;
          assert ({o_data, o_col, o_row, o_cam_id} === {p.d, p.c, p.r, p.cam}) else begin
            bad++;
            $error("FAIL pixel observed d=%0d c=%0d r=%0d cam=%0d expected d=%0d c=%0d r=%0d cam=%0d",
                   o_data, o_col, o_row, o_cam_id, p.d, p.c, p.r, p.cam);
          end
        end
      end
      if (line_done) done_cnt++;
      if (err) begin
        total++;
        assert (err_q.size() != 0) else begin
          bad++;
          $error("FAIL err_unexpected observed_code=%0d expected=none", err_code);
        end
        if (err_q.size() != 0) chk("err_code", 32'(err_code), 32'(err_q.pop_front()));
      end
    end
  end

  initial begin
    rstn = 1'b1; rx_valid = 1'b0; rx_data = '0; rx_data_len = '0;
    m_exp[0] = '0; m_exp[1] = '0;
    #2 rstn = 1'b0;
    #1;
    chk("rst_o_valid", 32'(o_valid), 0);
    chk("rst_line_done", 32'(line_done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_outs", {o_data, o_col, o_row, o_cam_id}, 0);
    chk("rst_err_code", 32'(err_code), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    pix_mark = pix_cnt;
    send_pkt(CAM1, 10'd0, GOOD_LEN, NPIX);
    chk("good_pix_cnt", 32'(pix_cnt - pix_mark), NPIX);
    chk("good_done", 32'(done_cnt), 1);
    chk("good_err_cnt", 32'(err_cnt), 0);

    pix_mark = pix_cnt;
    send_pkt(CAM1, 10'd1, 16'd1000, NPIX);
    chk("len_no_pix", 32'(pix_cnt - pix_mark), 0);
    chk("len_err_cnt", 32'(err_cnt), 1);
    send_pkt(CAM1, 10'd1, GOOD_LEN, NPIX);
    chk("after_len_done", 32'(done_cnt), 2);

    pix_mark = pix_cnt;
    send_pkt(6'b111111, 10'd2, GOOD_LEN, NPIX);
    send_pkt(CAM1, 10'd720, GOOD_LEN, NPIX);
    chk("id_range_no_pix", 32'(pix_cnt - pix_mark), 0);
    chk("id_range_err_cnt", 32'(err_cnt), 3);

    pix_mark = pix_cnt;
    send_pkt(CAM1, 10'd2, GOOD_LEN, 500);
    chk("trunc_pix_cnt", 32'(pix_cnt - pix_mark), 500);
    chk("trunc_no_done", 32'(done_cnt), 2);

    pix_mark = pix_cnt;
    send_pkt(CAM1, 10'd2, GOOD_LEN, 1288);
    chk("overrun_pix_cnt", 32'(pix_cnt - pix_mark), NPIX);
    chk("overrun_no_done", 32'(done_cnt), 2);

    send_pkt(CAM2, 10'd0, GOOD_LEN, NPIX);
    send_pkt(CAM2, 10'd1, GOOD_LEN, NPIX);
    pix_mark = pix_cnt;
    send_pkt(CAM2, 10'd3, GOOD_LEN, NPIX);
    chk("seq_still_emitted", 32'(pix_cnt - pix_mark), NPIX);
    chk("seq_err_code", 32'(err_code), 6);

    send_pkt(CAM1, 10'd719, GOOD_LEN, NPIX);
    send_pkt(CAM1, 10'd0, GOOD_LEN, NPIX);
    chk("wrap_done", 32'(done_cnt), exp_done);
    chk("wrap_err_cnt", 32'(err_cnt), 32'(exp_err_cnt));

    // reset asserted mid-line; the tail of the packet then looks like a new packet
    for (int j = 0; j < 600; j++) begin
      pix_t p;
      p.d = 8'(j); p.c = 11'(j); p.r = m_exp[1]; p.cam = 1'b1;
      pix_q.push_back(p);
    end
    @(negedge clk);
    rx_valid = 1'b1; rx_data = {CAM1, m_exp[1][9:8]}; rx_data_len = GOOD_LEN;
    @(negedge clk);
    rx_data = m_exp[1][7:0];
    for (int i = 0; i < NPIX; i++) begin
      @(negedge clk);
      if (i == 600) begin
        rstn = 1'b0;
        #1;
        chk("mid_rst_o_valid", 32'(o_valid), 0);
        chk("mid_rst_outs", {o_data, o_col, o_row, o_cam_id}, 0);
        chk("mid_rst_err_cnt", 32'(err_cnt), 0);
        chk("mid_rst_pix_q", 32'(pix_q.size()), 0);
        m_exp[0] = '0; m_exp[1] = '0;
        exp_err_cnt = 0;
      end
      if (i == 603) begin
        rstn = 1'b1;
        model_pkt(8'(603), 8'(604), GOOD_LEN, NPIX - 605, 605);
      end
      rx_data = 8'(i);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_err_cnt", 32'(err_cnt), 1);
    chk("post_rst_err_code", 32'(err_code), 2);

    send_pkt(CAM1, 10'd0, GOOD_LEN, NPIX);
    chk("final_done", 32'(done_cnt), exp_done);
    chk("final_err_cnt", 32'(err_cnt), 32'(exp_err_cnt));
    chk("pix_q_empty", 32'(pix_q.size()), 0);
    chk("err_q_empty", 32'(err_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
